// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer for a group of dataflow functional units.
//
// A start request pulses the group init for one cycle and then enables the
// group for a programmed number of iterations. Stalls freeze progress. After
// the last iteration the block waits a programmed drain latency and then
// pulses done for one cycle.
//
// Ports:
//   RUN_CTRL_clk            clock
//   RUN_CTRL_reset          synchronous active-high reset
//   RUN_CTRL_init           synchronous active-high soft clear (same effect as reset)
//   RUN_CTRL_in_start       start request, sampled only in IDLE
//   RUN_CTRL_in_len         iteration count, latched on an accepted start
//   RUN_CTRL_in_latency     drain cycles after the last iteration, latched on start
//   RUN_CTRL_in_stall       stall request from downstream
//   RUN_CTRL_out_fu_init    one-cycle init pulse to the FU group
//   RUN_CTRL_out_fu_disable FU hold; passes the stall through in RUN/DRAIN
//   RUN_CTRL_out_busy       high from INIT through DRAIN
//   RUN_CTRL_out_done       one-cycle completion pulse
//   RUN_CTRL_out_iter       completed iteration count
module run_ctrl #(
  parameter int CNT_W = 32,
  parameter int LAT_W = 8
) (
  input  logic             RUN_CTRL_clk,
  input  logic             RUN_CTRL_reset,
  input  logic             RUN_CTRL_init,
  input  logic             RUN_CTRL_in_start,
  input  logic [CNT_W-1:0] RUN_CTRL_in_len,
  input  logic [LAT_W-1:0] RUN_CTRL_in_latency,
  input  logic             RUN_CTRL_in_stall,
  output logic             RUN_CTRL_out_fu_init,
  output logic             RUN_CTRL_out_fu_disable,
  output logic             RUN_CTRL_out_busy,
  output logic             RUN_CTRL_out_done,
  output logic [CNT_W-1:0] RUN_CTRL_out_iter
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LAT_W-1:0] LAT_ZERO = '0;
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  // Soft clear and reset are indistinguishable to the sequencer.
  logic clr;
  assign clr = RUN_CTRL_reset | RUN_CTRL_init;

  always_ff @(posedge RUN_CTRL_clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      len_q   <= CNT_ZERO;
      lat_q   <= LAT_ZERO;
      drain_q <= LAT_ZERO;
      iter_q  <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lat_q   <= lat_d;
      drain_q <= drain_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lat_d   = lat_q;
    drain_d = drain_q;
    iter_d  = iter_q;

    unique case (state_q)
      S_IDLE: begin
        if (RUN_CTRL_in_start) begin
          iter_d = CNT_ZERO;
          if (RUN_CTRL_in_len != CNT_ZERO) begin
            len_d   = RUN_CTRL_in_len;
            lat_d   = RUN_CTRL_in_latency;
            state_d = S_INIT;
          end else begin
            // Zero-length run completes immediately without touching the FUs.
            state_d = S_DONE;
          end
        end
      end
      S_INIT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (!RUN_CTRL_in_stall) begin
          iter_d = iter_q + CNT_ONE;
          // Compare against len-1 so a maximum-length run never needs iter to wrap.
          if (iter_q == len_q - CNT_ONE) begin
            if (lat_q != LAT_ZERO) begin
              drain_d = lat_q;
              state_d = S_DRAIN;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!RUN_CTRL_in_stall) begin
          drain_d = drain_q - LAT_ONE;
          if (drain_q == LAT_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore decode; the only input-to-output path is the stall pass-through
  // while the FUs are actively iterating or draining.
  always_comb begin
    RUN_CTRL_out_fu_init    = (state_q == S_INIT);
    RUN_CTRL_out_busy       = (state_q == S_INIT) || (state_q == S_RUN) ||
                              (state_q == S_DRAIN);
    RUN_CTRL_out_done       = (state_q == S_DONE);
    RUN_CTRL_out_fu_disable = 1'b1;
    if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
      RUN_CTRL_out_fu_disable = RUN_CTRL_in_stall;
    end
  end

  assign RUN_CTRL_out_iter = iter_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl. Each accepted run pushes its expected done cycle and
// final iteration count into a queue; a monitor pops on every done pulse.
// Level checks of init/disable/busy are made inline at hand-computed cycles.
module tb_run_ctrl;

  localparam int CNT_W = 32;
  localparam int LAT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             soft_init = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic [LAT_W-1:0] lat = '0;
  logic             stall = 1'b0;
  logic             fu_init, fu_disable, busy, done;
  logic [CNT_W-1:0] iter;

  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    int unsigned      when;
    logic [CNT_W-1:0] iter;
  } exp_t;
  exp_t exp_q[$];

  run_ctrl #(.CNT_W(CNT_W), .LAT_W(LAT_W)) dut (
    .RUN_CTRL_clk           (clk),
    .RUN_CTRL_reset         (rst),
    .RUN_CTRL_init          (soft_init),
    .RUN_CTRL_in_start      (start),
    .RUN_CTRL_in_len        (len),
    .RUN_CTRL_in_latency    (lat),
    .RUN_CTRL_in_stall      (stall),
    .RUN_CTRL_out_fu_init   (fu_init),
    .RUN_CTRL_out_fu_disable(fu_disable),
    .RUN_CTRL_out_busy      (busy),
    .RUN_CTRL_out_done      (done),
    .RUN_CTRL_out_iter      (iter)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input longint exp_iter);
    check({name, " fu_init"}, fu_init, 0);
    check({name, " fu_disable"}, fu_disable, 1);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
    check({name, " iter"}, iter, exp_iter);
  endtask

  // Issue a start sampled on the next edge ("edge 0"); returns cyc after it.
  task automatic do_start(input int l, input int lt, output int unsigned s);
    len   = CNT_W'(l);
    lat   = LAT_W'(lt);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    $display("start len=%0d lat=%0d at cyc %0d", l, lt, s);
  endtask

  task automatic push_exp(input int unsigned when, input int it);
    exp_t e;
    e.when = when;
    e.iter = CNT_W'(it);
    exp_q.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done cycle", cyc, e.when);
        check("done iter", iter, e.iter);
        $display("done at cyc %0d iter %0d", cyc, iter);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;

    // Reset, then five idle cycles.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_idle("reset idle", 0);
      tick();
    end

    // len=4 lat=3, no stall: init cycle 1, enabled 2..8, done 9.
    do_start(4, 3, s);
    push_exp(s + 8, 4);
    check("t2 init c1", fu_init, 1);
    check("t2 dis c1", fu_disable, 1);
    check("t2 busy c1", busy, 1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      check("t2 dis run", fu_disable, 0);
      check("t2 init run", fu_init, 0);
      check("t2 busy run", busy, 1);
    end
    tick();
    check("t2 busy c9", busy, 0);
    check("t2 dis c9", fu_disable, 1);
    tick();
    check_idle("t2 after", 4);
    tick();

    // len=4 lat=0, stall during cycles 3 and 4: done moves to cycle 8.
    do_start(4, 0, s);
    push_exp(s + 7, 4);
    tick();
    check("t3 dis c2", fu_disable, 0);
    check("t3 iter c2", iter, 0);
    tick();
    stall = 1'b1;
    #1;
    check("t3 dis c3", fu_disable, 1);
    check("t3 iter c3", iter, 1);
    tick();
    check("t3 dis c4", fu_disable, 1);
    check("t3 iter c4", iter, 1);
    tick();
    stall = 1'b0;
    #1;
    check("t3 dis c5", fu_disable, 0);
    check("t3 iter c5", iter, 1);
    tick();
    tick();
    check("t3 iter c7", iter, 3);
    tick();
    check("t3 iter c8", iter, 4);
    tick();
    check_idle("t3 after", 4);
    tick();

    // len=0: straight to DONE in cycle 1, never busy.
    do_start(0, 5, s);
    push_exp(s, 0);
    check("t4 init c1", fu_init, 0);
    check("t4 busy c1", busy, 0);
    check("t4 dis c1", fu_disable, 1);
    tick();
    check_idle("t4 after", 0);
    tick();

    // len=10 lat=2, reset in RUN at iter=5: abort with no done pulse.
    do_start(10, 2, s);
    for (int c = 2; c <= 7; c++) tick();
    check("t5 iter c7", iter, 5);
    check("t5 busy c7", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("t5 aborted", 0);
    tick();
    do_start(2, 0, s);
    push_exp(s + 3, 2);
    for (int c = 2; c <= 4; c++) tick();
    tick();
    check_idle("t5 rerun", 2);

    // Soft clear behaves like reset mid-run.
    do_start(6, 0, s);
    tick();
    tick();
    soft_init = 1'b1;
    tick();
    soft_init = 1'b0;
    check_idle("t5b soft clear", 0);
    tick();

    // Start held high, len=1 lat=1: runs of 4 cycles, done every 5.
    len   = CNT_W'(1);
    lat   = LAT_W'(1);
    start = 1'b1;
    tick();
    s = cyc;
    push_exp(s + 3, 1);
    push_exp(s + 8, 1);
    push_exp(s + 13, 1);
    check("t6 init c1", fu_init, 1);
    for (int c = 2; c <= 15; c++) begin
      tick();
      check("t6 busy", busy, ((c % 5) >= 1 && (c % 5) <= 3) ? 1 : 0);
      check("t6 init", fu_init, ((c % 5) == 1) ? 1 : 0);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_idle("t6 after", 1);
    check("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
